// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the multi-cycle FSM state type and the forwarding priority helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  // The youngest producer (EX/MEM) wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mc_stall_fsm.sv
// Holds the pipeline while a multi-cycle op occupies EX for MC_LAT cycles.
// mc_hold is raised combinationally on the op's first EX cycle.
module mc_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_mc_op,
  output logic mc_hold
);

  localparam int   CW       = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam int   INIT_VAL = (MC_LAT > 2) ? (MC_LAT - 2) : 0;
  localparam logic MC_EN    = (MC_LAT > 1);
  localparam logic [CW-1:0] CNT_INIT = INIT_VAL[CW-1:0];

  mc_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (ex_mc_op && MC_EN) begin
          state_d = MC_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      MC_BUSY: begin
        // The count-zero cycle is the release cycle; ex_mc_op still shows the old op.
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mc_hold = 1'b0;
    case (state_q)
      RUN:     mc_hold = ex_mc_op & MC_EN;
      MC_BUSY: mc_hold = (cnt_q != '0);
      default: mc_hold = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding control for the 5-stage pipeline: load-use and branch
// stalls, EX/ID forwarding, multi-cycle EX hold and a saturating stall counter.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic              id_use_rs,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              id_br_taken,
  input  logic [REG_AW-1:0] ex_rs_addr,
  input  logic [REG_AW-1:0] ex_rt_addr,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_reg_w,
  input  logic              ex_mem_r,
  input  logic              ex_mc_op,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_reg_w,
  input  logic              mem_mem_r,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_reg_w,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              id_ex_hold,
  output logic              ex_mem_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_br_a,
  output logic              fwd_br_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic reg_match(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return (src == dst) && (dst != '0);
  endfunction

  logic mc_hold;
  logic rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic id_hit_ex, id_hit_mem;
  logic ld_stall, br_stall;
  logic [CNT_W-1:0] stall_cnt_q;

  mc_stall_fsm #(.MC_LAT(MC_LAT)) u_mc_fsm (
    .clk      (clk),
    .rst      (rst),
    .ex_mc_op (ex_mc_op),
    .mc_hold  (mc_hold)
  );

  assign rs_hit_ex  = id_use_rs & reg_match(id_rs_addr, ex_rd_addr);
  assign rt_hit_ex  = id_use_rt & reg_match(id_rt_addr, ex_rd_addr);
  assign rs_hit_mem = id_use_rs & reg_match(id_rs_addr, mem_rd_addr);
  assign rt_hit_mem = id_use_rt & reg_match(id_rt_addr, mem_rd_addr);
  assign id_hit_ex  = rs_hit_ex | rt_hit_ex;
  assign id_hit_mem = rs_hit_mem | rt_hit_mem;

  assign ld_stall = ex_mem_r & ex_reg_w & id_hit_ex;
  // A load in MEM cannot be forwarded to the ID comparator, so it stalls too.
  assign br_stall = id_is_branch & ((ex_reg_w & id_hit_ex) | (mem_mem_r & id_hit_mem));

  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_bubble = 1'b0;
    fwd_a         = FWD_RF;
    fwd_b         = FWD_RF;
    fwd_br_a      = 1'b0;
    fwd_br_b      = 1'b0;
    if (rst) begin
      id_ex_bubble = 1'b1;
    end else begin
      fwd_a    = fwd_sel(mem_reg_w & reg_match(ex_rs_addr, mem_rd_addr),
                         wb_reg_w  & reg_match(ex_rs_addr, wb_rd_addr));
      fwd_b    = fwd_sel(mem_reg_w & reg_match(ex_rt_addr, mem_rd_addr),
                         wb_reg_w  & reg_match(ex_rt_addr, wb_rd_addr));
      fwd_br_a = id_is_branch & rs_hit_mem & mem_reg_w & ~mem_mem_r;
      fwd_br_b = id_is_branch & rt_hit_mem & mem_reg_w & ~mem_mem_r;
      if (mc_hold) begin
        id_ex_hold    = 1'b1;
        ex_mem_bubble = 1'b1;
      end else if (ld_stall || br_stall) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = id_is_branch & id_br_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: a driver issues directed then random cycles and queues the
// outputs a behavioural model predicts; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int AW     = 5;
  localparam int MC_LAT = 4;
  localparam int CW     = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] id_rs;
    logic          use_rs;
    logic [AW-1:0] id_rt;
    logic          use_rt;
    logic          br;
    logic          taken;
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_w;
    logic          ex_mem_r;
    logic          ex_mc;
    logic [AW-1:0] mem_rd;
    logic          mem_reg_w;
    logic          mem_mem_r;
    logic [AW-1:0] wb_rd;
    logic          wb_reg_w;
  } stim_t;

  typedef struct packed {
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic          id_ex_hold;
    logic          ex_mem_bubble;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          fwd_br_a;
    logic          fwd_br_b;
    logic [CW-1:0] stall_cnt;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic id_use_rs, id_use_rt, id_is_branch, id_br_taken, ex_reg_w, ex_mem_r, ex_mc_op;
  logic mem_reg_w, mem_mem_r, wb_reg_w;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic fwd_br_a, fwd_br_b;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .MC_LAT(MC_LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_use_rs(id_use_rs),
    .id_rt_addr(id_rt_addr), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_br_taken(id_br_taken),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
    .ex_reg_w(ex_reg_w), .ex_mem_r(ex_mem_r), .ex_mc_op(ex_mc_op),
    .mem_rd_addr(mem_rd_addr), .mem_reg_w(mem_reg_w), .mem_mem_r(mem_mem_r),
    .wb_rd_addr(wb_rd_addr), .wb_reg_w(wb_reg_w),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_br_a(fwd_br_a), .fwd_br_b(fwd_br_b),
    .stall_cnt(stall_cnt)
  );

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  // Reference state: EX cycles left for the resident multi-cycle op, and stalls seen.
  int busy_left   = 0;
  int stall_total = 0;

  function automatic bit hit(input logic [AW-1:0] src, input logic [AW-1:0] dst);
    return (src == dst) && (dst != 0);
  endfunction

  function automatic logic [1:0] pick(input bit mem_hit, input bit wb_hit);
    return mem_hit ? 2'd2 : (wb_hit ? 2'd1 : 2'd0);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic step(input stim_t s);
    out_t e;
    bit   rs_ex, rt_ex, rs_mem, rt_mem, hold, data_stall;
    @(posedge clk);
    #1;
    rst = s.rst;
    id_rs_addr = s.id_rs;   id_use_rs = s.use_rs;
    id_rt_addr = s.id_rt;   id_use_rt = s.use_rt;
    id_is_branch = s.br;    id_br_taken = s.taken;
    ex_rs_addr = s.ex_rs;   ex_rt_addr = s.ex_rt;   ex_rd_addr = s.ex_rd;
    ex_reg_w = s.ex_reg_w;  ex_mem_r = s.ex_mem_r;  ex_mc_op = s.ex_mc;
    mem_rd_addr = s.mem_rd; mem_reg_w = s.mem_reg_w; mem_mem_r = s.mem_mem_r;
    wb_rd_addr = s.wb_rd;   wb_reg_w = s.wb_reg_w;

    rs_ex  = s.use_rs && hit(s.id_rs, s.ex_rd);
    rt_ex  = s.use_rt && hit(s.id_rt, s.ex_rd);
    rs_mem = s.use_rs && hit(s.id_rs, s.mem_rd);
    rt_mem = s.use_rt && hit(s.id_rt, s.mem_rd);
    if (!s.rst && busy_left == 0 && s.ex_mc) busy_left = MC_LAT;
    hold = !s.rst && (busy_left > 1);
    data_stall = (s.ex_mem_r && s.ex_reg_w && (rs_ex || rt_ex)) ||
                 (s.br && ((s.ex_reg_w && (rs_ex || rt_ex)) || (s.mem_mem_r && (rs_mem || rt_mem))));

    e = '0;
    e.stall_cnt = CW'(stall_total);
    if (s.rst) begin
      e.id_ex_bubble = 1'b1;
    end else begin
      e.fwd_a = pick(s.mem_reg_w && hit(s.ex_rs, s.mem_rd), s.wb_reg_w && hit(s.ex_rs, s.wb_rd));
      e.fwd_b = pick(s.mem_reg_w && hit(s.ex_rt, s.mem_rd), s.wb_reg_w && hit(s.ex_rt, s.wb_rd));
      e.fwd_br_a = s.br && rs_mem && s.mem_reg_w && !s.mem_mem_r;
      e.fwd_br_b = s.br && rt_mem && s.mem_reg_w && !s.mem_mem_r;
      if (hold) begin
        e.id_ex_hold = 1'b1;
        e.ex_mem_bubble = 1'b1;
      end else if (data_stall) begin
        e.id_ex_bubble = 1'b1;
      end else begin
        e.pc_write = 1'b1;
        e.if_id_write = 1'b1;
        e.if_id_flush = s.br && s.taken;
      end
    end
    exp_q.push_back(e);

    if (s.rst) begin
      busy_left = 0;
      stall_total = 0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (!e.pc_write && stall_total < CNT_MAX) stall_total++;
    end
  endtask

  always @(negedge clk) begin
    out_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble,
           fwd_a, fwd_b, fwd_br_a, fwd_br_b, stall_cnt};
      total++;
      txn++;
      if (a !== e) begin
        bad++;
        $display("FAIL txn%0d outputs act=%b exp=%b (pc,ifw,fl,bub,hold,exb,fa,fb,bra,brb,cnt)", txn, a, e);
      end else begin
        $display("txn %0d ok out=%b", txn, a);
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    id_rs_addr = '0; id_rt_addr = '0; ex_rs_addr = '0; ex_rt_addr = '0;
    ex_rd_addr = '0; mem_rd_addr = '0; wb_rd_addr = '0;
    id_use_rs = 0; id_use_rt = 0; id_is_branch = 0; id_br_taken = 0;
    ex_reg_w = 0; ex_mem_r = 0; ex_mc_op = 0; mem_reg_w = 0; mem_mem_r = 0; wb_reg_w = 0;
    repeat (2) @(posedge clk);

    s = idle(); s.rst = 1; step(s);
    // lw $2 in EX, add $3,$2,$4 in ID: one load-use stall
    s = idle(); s.ex_rd = 2; s.ex_reg_w = 1; s.ex_mem_r = 1;
    s.id_rs = 2; s.use_rs = 1; s.id_rt = 4; s.use_rt = 1; step(s);
    s = idle(); s.mem_rd = 2; s.mem_reg_w = 1; s.mem_mem_r = 1;
    s.id_rs = 2; s.use_rs = 1; s.id_rt = 4; s.use_rt = 1; step(s);
    s = idle(); s.ex_rs = 2; s.ex_rt = 4; s.ex_rd = 3; s.ex_reg_w = 1; s.wb_rd = 2; s.wb_reg_w = 1; step(s);
    // add $2 then sub $5,$2,$2; then $0 as destination
    s = idle(); s.ex_rs = 2; s.ex_rt = 2; s.mem_rd = 2; s.mem_reg_w = 1; s.wb_rd = 2; s.wb_reg_w = 1; step(s);
    s = idle(); s.ex_rs = 0; s.ex_rt = 0; s.mem_rd = 0; s.mem_reg_w = 1; s.wb_rd = 0; s.wb_reg_w = 1; step(s);
    // add $2 in EX, taken beq $2,$3 in ID
    s = idle(); s.ex_rd = 2; s.ex_reg_w = 1; s.br = 1; s.taken = 1;
    s.id_rs = 2; s.use_rs = 1; s.id_rt = 3; s.use_rt = 1; step(s);
    s = idle(); s.mem_rd = 2; s.mem_reg_w = 1; s.br = 1; s.taken = 1;
    s.id_rs = 2; s.use_rs = 1; s.id_rt = 3; s.use_rt = 1; step(s);
    // mul in EX with a load-use hazard present: hold wins, then release
    for (int i = 0; i < MC_LAT; i++) begin
      s = idle(); s.ex_mc = 1; s.ex_rd = 6; s.ex_reg_w = 1; s.ex_mem_r = 1;
      s.id_rs = 6; s.use_rs = 1; step(s);
    end
    s = idle(); step(s);
    // reset in the middle of a multi-cycle op
    s = idle(); s.ex_mc = 1; step(s);
    s = idle(); s.ex_mc = 1; step(s);
    s = idle(); s.ex_mc = 1; s.rst = 1; step(s);
    s = idle(); step(s);

    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.rst       = ($urandom_range(0, 59) == 0);
      s.id_rs     = AW'($urandom_range(0, 3));
      s.id_rt     = AW'($urandom_range(0, 3));
      s.use_rs    = $urandom_range(0, 3) != 0;
      s.use_rt    = $urandom_range(0, 1) != 0;
      s.br        = $urandom_range(0, 2) == 0;
      s.taken     = $urandom_range(0, 1) != 0;
      s.ex_rs     = AW'($urandom_range(0, 3));
      s.ex_rt     = AW'($urandom_range(0, 3));
      s.ex_rd     = AW'($urandom_range(0, 3));
      s.ex_reg_w  = $urandom_range(0, 1) != 0;
      s.ex_mem_r  = $urandom_range(0, 2) == 0;
      s.ex_mc     = $urandom_range(0, 9) == 0;
      s.mem_rd    = AW'($urandom_range(0, 3));
      s.mem_reg_w = $urandom_range(0, 1) != 0;
      s.mem_mem_r = $urandom_range(0, 2) == 0;
      s.wb_rd     = AW'($urandom_range(0, 3));
      s.wb_reg_w  = $urandom_range(0, 1) != 0;
      step(s);
    end

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
